// File: rtl/clk_gate_ctrl.sv
// Activity-based enable controller for a latch-based test clock-gating cell.
// It gates after a run of idle cycles and wakes with a delayed READY.
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8,
    parameter int STAT_W      = 16
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              BUSY,
    input  logic              FORCE_ON,
    input  logic              TE,
    output logic              E,
    output logic              SE,
    output logic              READY,
    output logic              GATED,
    output logic [STAT_W-1:0] GATED_CNT,
    output logic [1:0]        STATE
);

    // Handshake: a transfer is accepted on a CK edge where REQ=1 and READY=1;
    // the requester holds REQ until that edge, and REQ counts as activity.

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_GATED = 2'd1,
        S_WAKE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LIM = CNT_W'(WAKE_CYCLES);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              act;

    assign act     = REQ | BUSY | FORCE_ON;
    assign cnt_inc = cnt + 1'b1;
    // The gating cell overrides E itself in scan mode, so SE bypasses the FSM.
    assign SE      = TE;
    assign STATE   = state;

    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= S_RUN;
            cnt       <= '0;
            E         <= 1'b1;
            READY     <= 1'b1;
            GATED     <= 1'b0;
            GATED_CNT <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (act) begin
                        cnt <= '0;
                    end else if (cnt_inc == IDLE_LIM) begin
                        state <= S_GATED;
                        cnt   <= '0;
                        E     <= 1'b0;
                        READY <= 1'b0;
                        GATED <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_GATED: begin
                    // Every edge taken here counts, including the one leaving.
                    if (GATED_CNT != '1) begin
                        GATED_CNT <= GATED_CNT + 1'b1;
                    end
                    if (act) begin
                        cnt   <= '0;
                        E     <= 1'b1;
                        GATED <= 1'b0;
                        if (WAKE_CYCLES == 0) begin
                            state <= S_RUN;
                            READY <= 1'b1;
                        end else begin
                            state <= S_WAKE;
                            READY <= 1'b0;
                        end
                    end
                end
                S_WAKE: begin
                    if (cnt_inc == WAKE_LIM) begin
                        state <= S_RUN;
                        cnt   <= '0;
                        READY <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                    E     <= 1'b1;
                    READY <= 1'b1;
                    GATED <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: default, fast (IDLE=1, WAKE=0) and
// narrow-status (STAT_W=4) instances share one stimulus stream.
module tb_clk_gate_ctrl;

    logic ck = 1'b0;
    logic rst, req, busy, force_on, te;

    logic        e0, se0, ready0, gated0;
    logic [15:0] gcnt0;
    logic [1:0]  st0;
    logic        e1, se1, ready1, gated1;
    logic [15:0] gcnt1;
    logic [1:0]  st1;
    logic        e2, se2, ready2, gated2;
    logic [3:0]  gcnt2;
    logic [1:0]  st2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ck = ~ck;

    clk_gate_ctrl u0 (
        .CK(ck), .RST(rst), .REQ(req), .BUSY(busy), .FORCE_ON(force_on), .TE(te),
        .E(e0), .SE(se0), .READY(ready0), .GATED(gated0), .GATED_CNT(gcnt0), .STATE(st0)
    );

    clk_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(0)) u1 (
        .CK(ck), .RST(rst), .REQ(req), .BUSY(busy), .FORCE_ON(force_on), .TE(te),
        .E(e1), .SE(se1), .READY(ready1), .GATED(gated1), .GATED_CNT(gcnt1), .STATE(st1)
    );

    clk_gate_ctrl #(.STAT_W(4)) u2 (
        .CK(ck), .RST(rst), .REQ(req), .BUSY(busy), .FORCE_ON(force_on), .TE(te),
        .E(e2), .SE(se2), .READY(ready2), .GATED(gated2), .GATED_CNT(gcnt2), .STATE(st2)
    );

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; busy = 1'b0; force_on = 1'b0; te = 1'b0;
        #2;

        // Reset then idle on the default instance.
        do_reset();
        check("rst_e", e0, 1);
        check("rst_ready", ready0, 1);
        check("rst_gated", gated0, 0);
        check("rst_gcnt", gcnt0, 0);
        check("rst_state", st0, 0);
        check("rst_se", se0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("idle_e_%0d", i), e0, (i < 16) ? 1 : 0);
            check($sformatf("idle_gated_%0d", i), gated0, (i < 16) ? 0 : 1);
            check($sformatf("idle_gcnt_%0d", i), gcnt0, (i > 16) ? i - 16 : 0);
        end
        check("idle_ready", ready0, 0);

        // Near miss: BUSY on the 16th edge restarts the idle run.
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            tick();
            check($sformatf("near_e_%0d", i), e0, 1);
        end
        busy = 1'b1;
        tick();
        check("near_busy_e", e0, 1);
        busy = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("near_after_e_%0d", i), e0, (i < 16) ? 1 : 0);
        end
        check("near_gated", gated0, 1);

        // Wake handshake from GATED.
        tick();
        tick();
        check("wake_pre_gcnt", gcnt0, 2);
        req = 1'b1;
        tick();
        check("wake_w_e", e0, 1);
        check("wake_w_ready", ready0, 0);
        check("wake_w_gated", gated0, 0);
        check("wake_w_gcnt", gcnt0, 3);
        check("wake_w_state", st0, 2);
        tick();
        check("wake_w1_ready", ready0, 0);
        check("wake_w1_e", e0, 1);
        tick();
        check("wake_w2_ready", ready0, 1);
        check("wake_w2_state", st0, 0);
        check("wake_accept", req & ready0, 1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("wake_hold_gated_%0d", i), gated0, 0);
        end
        req = 1'b0;
        tick();
        check("wake_hold_gcnt", gcnt0, 3);

        // Fast instance: IDLE_CYCLES=1, WAKE_CYCLES=0.
        do_reset();
        check("fast_rst_e", e1, 1);
        tick();
        check("fast_gate_e", e1, 0);
        check("fast_gate_gated", gated1, 1);
        check("fast_gate_ready", ready1, 0);
        busy = 1'b1;
        tick();
        check("fast_wake_e", e1, 1);
        check("fast_wake_ready", ready1, 1);
        check("fast_wake_gated", gated1, 0);
        check("fast_wake_gcnt", gcnt1, 1);
        busy = 1'b0;
        tick();
        check("fast_regate", gated1, 1);
        check("fast_regate_gcnt", gcnt1, 1);

        // Reset during WAKE, with ACT still high.
        do_reset();
        for (int i = 1; i <= 19; i++) tick();
        check("mid_pre_gcnt", gcnt0, 3);
        req = 1'b1;
        tick();
        check("mid_wake_state", st0, 2);
        check("mid_wake_ready", ready0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 1'b0;
        check("mid_rst_e", e0, 1);
        check("mid_rst_ready", ready0, 1);
        check("mid_rst_gcnt", gcnt0, 0);
        check("mid_rst_state", st0, 0);

        // TE drives SE immediately and leaves the FSM alone.
        te = 1'b1;
        #1;
        check("te_se_hi", se0, 1);
        check("te_e", e0, 1);
        check("te_state", st0, 0);
        for (int i = 1; i <= 16; i++) tick();
        check("te_gated", gated0, 1);
        check("te_gated_e", e0, 0);
        te = 1'b0;
        #1;
        check("te_se_lo", se0, 0);
        check("te_still_gated", gated0, 1);
        te = 1'b1;
        rst = 1'b1;
        #1;
        check("te_se_in_rst", se0, 1);
        tick();
        rst = 1'b0;
        te = 1'b0;

        // Saturation with a 4-bit status counter.
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 16) check("sat_gated", gated2, 1);
            if (i == 30) check("sat_30", gcnt2, 14);
            if (i == 31) check("sat_31", gcnt2, 15);
            if (i == 32) check("sat_32", gcnt2, 15);
        end
        check("sat_40", gcnt2, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Activity-based enable controller that drives the E and SE inputs of the team's latch-based test clock-gating cell. It watches request and busy activity of the gated domain, drops E after a programmable run of idle cycles, and restores it on new activity with a wake-up delay and READY handshake. A saturating counter reports how many cycles the clock has been gated. It sits directly upstream of the gating cell, in the ungated CK domain.

## Interface
- IDLE_CYCLES, 16, consecutive idle samples required before gating; legal range 1..2^CNT_W-1
- WAKE_CYCLES, 2, cycles E is held high before READY rises after wake; legal range 0..2^CNT_W-1
- CNT_W, 8, width of the internal idle/wake counter
- STAT_W, 16, width of GATED_CNT
- CK  input  1  free-running clock, rising-edge active
- RST  input  1  synchronous, active-high reset
- REQ  input  1  requester wants the gated domain; held until REQ&READY
- BUSY  input  1  gated domain has work in flight
- FORCE_ON  input  1  software override, counts as activity
- TE  input  1  scan test enable
- E  output  1  functional enable to gating cell (registered)
- SE  output  1  test enable to gating cell, equal to TE (combinational)
- READY  output  1  gated clock is running and stable (registered)
- GATED  output  1  status, high while in GATED state (registered)
- GATED_CNT  output  STAT_W  saturating count of cycles spent in GATED

## Operation
- Activity (ACT) = REQ | BUSY | FORCE_ON, sampled on each CK rising edge; idle sample = ACT low.
- States: RUN, GATED, WAKE. Reset state is RUN.
- RUN: E=1, READY=1, GATED=0. ACT=1 clears the counter. Idle sample increments it. The idle sample that makes the count equal IDLE_CYCLES moves the FSM to GATED at that edge, and the counter clears.
- GATED: E=0, READY=0, GATED=1. GATED_CNT increments on every edge in this state and saturates at all-ones. ACT=1 moves the FSM to WAKE, or to RUN if WAKE_CYCLES=0, with the counter cleared.
- WAKE: E=1, READY=0, GATED=0. The counter increments each edge. The edge that makes the count equal WAKE_CYCLES moves the FSM to RUN. ACT is ignored, and WAKE never returns directly to GATED.
- Handshake: a transfer is accepted on an edge where REQ=1 and READY=1. The requester holds REQ until then. REQ held high in RUN keeps the clock on indefinitely.
- SE = TE at all times, independent of state and reset. The FSM keeps running while TE=1, because the gating cell forces GCK on by itself.
- Counter arithmetic is unsigned CNT_W bits. Comparisons are equality against the parameter, so the counter never wraps.

## Timing
- Reset (RST=1 at an edge) gives: state RUN, E=1, READY=1, GATED=0, counter=0, GATED_CNT=0, all visible after that edge. The same applies mid-operation from any state, including WAKE, and reset takes priority over ACT.
- Gating latency: with activity last seen at edge k, and idle samples at edges k+1..k+IDLE_CYCLES, E falls after edge k+IDLE_CYCLES.
- ACT=1 on the same edge as the IDLE_CYCLES-th would-be idle sample means no gating and a counter clear.
- Wake latency: with ACT first seen in GATED at edge w, E rises after edge w, and READY rises after edge w+WAKE_CYCLES (same edge as E when WAKE_CYCLES=0).
- The gating cell captures E while CK is low, so the first GCK pulse occurs in the high phase after E rises. WAKE_CYCLES>=1 guarantees at least one clean pulse before READY.
- GATED_CNT changes only on edges taken in the GATED state, including the edge that leaves it. With STAT_W=16 it holds at 0xFFFF.

## Test plan
- Reset then idle: RST 1 cycle, ACT=0 for 20 cycles, defaults. Required: E=1/READY=1 after reset; E=0 and GATED=1 after the 16th idle edge; GATED_CNT increments from 0.
- Near-miss: 15 idle cycles then BUSY=1 for 1 cycle, then idle. Required: E stays 1 throughout; gating occurs 16 idle edges after the BUSY pulse.
- Wake handshake: from GATED, assert REQ at edge w and hold it. Required: E=1 after w; READY=0 after w and w+1; READY=1 after w+2; REQ&READY accepted at edge w+3; no return to GATED while REQ is high.
- WAKE_CYCLES=0 and IDLE_CYCLES=1: one idle edge gives GATED; the next ACT edge gives E=1 and READY=1 together.
- Reset mid-WAKE and TE: RST during WAKE gives E=1, READY=1, GATED_CNT=0 after that edge. Toggling TE changes SE in the same cycle, with no effect on E or the state.
- Saturation: STAT_W=4, hold idle for 40 cycles. Required: GATED_CNT reaches 15 and stays at 15.
